// File: rtl/fft_share_sched.sv
// rtl/fft_share_sched.sv - round-robin frame scheduler sharing one IFFT/FFT core between two sources
//
// Purpose: grants whole N-sample frames to requester 0 or 1 in round-robin
// order and muxes the granted stream onto the core input. It also tracks
// frames in flight and tags every core output sample with its requester id.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req0/req1                        frame ready, held until the matching grant rises
//   grant0/grant1                    requester owns the core input for this frame
//   in_valid0/1, x_real0/1, x_img0/1 requester sample streams
//   core_in_valid, core_x_real/img   muxed stream to the core
//   core_out_valid                   core output strobe
//   out_valid, out_id, out_last      tagged output strobe, requester id, last sample of frame
//   busy                             a frame is granted or still in flight
//   err                              sticky: core output seen with nothing in flight
module fft_share_sched #(
    parameter int N       = 256,
    parameter int MAX_OUT = 2,
    parameter int DW      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    output logic                 grant0,
    output logic                 grant1,
    input  logic                 in_valid0,
    input  logic                 in_valid1,
    input  logic signed [DW-1:0] x_real0,
    input  logic signed [DW-1:0] x_img0,
    input  logic signed [DW-1:0] x_real1,
    input  logic signed [DW-1:0] x_img1,
    output logic                 core_in_valid,
    output logic signed [DW-1:0] core_x_real,
    output logic signed [DW-1:0] core_x_img,
    input  logic                 core_out_valid,
    output logic                 out_valid,
    output logic                 out_id,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);
    localparam int CW = $clog2(N);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic            gnt_id_q, gnt_id_d;
    logic            rr_last_q, rr_last_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [2:0]      outstanding_q, outstanding_d;
    logic            tag_q [4];
    logic [1:0]      rd_ptr_q, wr_ptr_q;
    logic            err_q;

    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic            slot_free;
    logic            winner;
    logic            do_grant;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(MAX_OUT - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // The tag FIFO occupancy equals outstanding, so no separate count is kept.
    assign fifo_empty = (outstanding_q == 3'd0);
    assign accept     = (state_q == STREAM) && (gnt_id_q ? in_valid1 : in_valid0);
    assign out_last   = core_out_valid && (out_cnt_q == CW'(N - 1));
    assign pop        = out_last && !fifo_empty;
    // A slot freed by an out_last this cycle can be reused at the same edge,
    // so a throttled grant appears the cycle right after that out_last.
    assign slot_free  = (outstanding_q < 3'(MAX_OUT)) || pop;
    assign winner     = (req0 && req1) ? ~rr_last_q : req1;
    assign do_grant   = (state_q == IDLE) && (req0 || req1) && slot_free;

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        rr_last_d = rr_last_q;
        in_cnt_d  = in_cnt_q;
        case (state_q)
            IDLE: begin
                if (do_grant) begin
                    state_d  = STREAM;
                    gnt_id_d = winner;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (in_cnt_q == CW'(N - 1)) begin
                        in_cnt_d  = '0;
                        rr_last_d = gnt_id_q;
                        state_d   = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (do_grant && !pop) begin
            outstanding_d = outstanding_q + 3'd1;
        end else if (pop && !do_grant) begin
            outstanding_d = outstanding_q - 3'd1;
        end
        out_cnt_d = core_out_valid ? out_cnt_q + 1'b1 : out_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_id_q      <= 1'b0;
            rr_last_q     <= 1'b1;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            outstanding_q <= 3'd0;
            rd_ptr_q      <= 2'd0;
            wr_ptr_q      <= 2'd0;
            err_q         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tag_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            gnt_id_q      <= gnt_id_d;
            rr_last_q     <= rr_last_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            outstanding_q <= outstanding_d;
            if (do_grant) begin
                tag_q[wr_ptr_q] <= winner;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (core_out_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign grant0        = (state_q == STREAM) && !gnt_id_q;
    assign grant1        = (state_q == STREAM) && gnt_id_q;
    assign core_in_valid = accept;
    assign core_x_real   = (state_q == STREAM) ? (gnt_id_q ? x_real1 : x_real0) : '0;
    assign core_x_img    = (state_q == STREAM) ? (gnt_id_q ? x_img1 : x_img0) : '0;
    assign out_valid     = core_out_valid;
    assign out_id        = fifo_empty ? 1'b0 : tag_q[rd_ptr_q];
    assign busy          = (state_q != IDLE) || !fifo_empty;
    assign err           = err_q;
endmodule

// File: tb/tb_fft_share_sched.sv
// tb/tb_fft_share_sched.sv - scoreboard bench for fft_share_sched
module tb_fft_share_sched;
    localparam int N  = 256;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req;
    logic [1:0]           inv;
    logic signed [DW-1:0] xr [2];
    logic signed [DW-1:0] xi [2];
    logic                 grant0, grant1;
    logic                 core_in_valid;
    logic signed [DW-1:0] core_x_real, core_x_img;
    logic                 core_out_valid;
    logic                 out_valid, out_id, out_last, busy, err;

    always #5 clk = ~clk;

    fft_share_sched #(.N(N), .MAX_OUT(2), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]),
        .grant0(grant0), .grant1(grant1),
        .in_valid0(inv[0]), .in_valid1(inv[1]),
        .x_real0(xr[0]), .x_img0(xi[0]), .x_real1(xr[1]), .x_img1(xi[1]),
        .core_in_valid(core_in_valid), .core_x_real(core_x_real), .core_x_img(core_x_img),
        .core_out_valid(core_out_valid),
        .out_valid(out_valid), .out_id(out_id), .out_last(out_last),
        .busy(busy), .err(err)
    );

    // Core model: output strobes are the input strobes delayed by lat cycles.
    logic [1023:0] dl;
    int            lat = 4;
    logic          inj;
    always @(posedge clk) begin
        if (!rst_n) dl <= '0;
        else        dl <= {dl[1022:0], core_in_valid};
    end
    assign core_out_valid = dl[lat-1] | inj;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [31:0] exp_in [$];
    logic [1:0]  exp_out [$];
    int          gid [$];
    int          gcyc [$];
    int          lcyc [$];
    int          cyc = 0;
    int          pulses;
    int          gcycles;
    bit          chk_busy = 1'b0;
    bit          busy_next = 1'b0;
    logic [1:0]  gprev = 2'b00;
    logic [31:0] e_in;
    logic [1:0]  e_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic grant_rise(input int id);
        gid.push_back(id);
        gcyc.push_back(cyc);
        chk("grant_excl", {31'd0, grant0 & grant1}, 32'd0);
        for (int i = 0; i < N; i++) exp_out.push_back({id[0], i == N - 1});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            gprev = 2'b00;
        end else begin
            if (busy_next) begin
                busy_next = 1'b0;
                chk("busy_fall", {31'd0, busy}, 32'd0);
            end
            if (grant0 && !gprev[0]) grant_rise(0);
            if (grant1 && !gprev[1]) grant_rise(1);
            gprev = {grant1, grant0};
            if (grant0 || grant1) gcycles++;
            if (core_in_valid) begin
                pulses++;
                if (exp_in.size() == 0) begin
                    chk("core_in_unexpected", 32'd1, 32'd0);
                end else begin
                    e_in = exp_in.pop_front();
                    chk("core_x_real", {16'h0, core_x_real}, {16'h0, e_in[31:16]});
                    chk("core_x_img", {16'h0, core_x_img}, {16'h0, e_in[15:0]});
                end
            end
            if (out_valid && !inj) begin
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", 32'd1, 32'd0);
                end else begin
                    e_out = exp_out.pop_front();
                    chk("out_id", {31'd0, out_id}, {31'd0, e_out[1]});
                    chk("out_last", {31'd0, out_last}, {31'd0, e_out[0]});
                    if (e_out[0]) begin
                        lcyc.push_back(cyc);
                        if (chk_busy) begin
                            chk("busy_at_last", {31'd0, busy}, 32'd1);
                            busy_next = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        req = 2'b00;
        inv = 2'b00;
        inj = 1'b0;
        xr[0] = '0; xr[1] = '0; xi[0] = '0; xi[1] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_in.delete();
        exp_out.delete();
        gid.delete();
        gcyc.delete();
        lcyc.delete();
        pulses = 0;
        gcycles = 0;
    endtask

    // Sends nfr frames from requester id; while waiting for its grant the
    // requester toggles junk onto its own stream, which must never reach the core.
    task automatic send(input int id, input int nfr, input bit gapped, input int abort_at,
                        output int first_wait);
        int  w;
        int  k;
        bit  ph;
        bit  v;
        first_wait = -1;
        for (int f = 0; f < nfr; f++) begin
            req[id] = 1'b1;
            w = 0;
            while (!(id == 0 ? grant0 : grant1) && w < 3000) begin
                inv[id] = ~inv[id];
                xr[id]  = 16'sh5A5A;
                xi[id]  = -16'sh1234;
                @(posedge clk);
                #1 w++;
            end
            if (!(id == 0 ? grant0 : grant1)) begin
                chk("grant_timeout", 32'd0, 32'd1);
                req[id] = 1'b0;
                inv[id] = 1'b0;
                return;
            end
            if (f == 0) first_wait = w;
            req[id] = 1'b0;
            k  = 0;
            ph = 1'b0;
            while (k < N) begin
                if (abort_at >= 0 && k == abort_at) begin
                    inv[id] = 1'b0;
                    return;
                end
                v       = gapped ? ph : 1'b1;
                ph      = ~ph;
                inv[id] = v;
                xr[id]  = 16'(k);
                xi[id]  = 16'(-k);
                if (v) begin
                    exp_in.push_back({16'(k), 16'(-k)});
                    k++;
                end
                @(posedge clk);
                #1;
            end
            inv[id] = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_out.size() != 0 || exp_in.size() != 0) && w < 4000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_out", exp_out.size(), 32'd0);
        chk("drain_in", exp_in.size(), 32'd0);
    endtask

    int fw0, fw1;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        lat = 4;
        reset_dut();
        chk("rst_grant0", {31'd0, grant0}, 32'd0);
        chk("rst_grant1", {31'd0, grant1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_core_in_valid", {31'd0, core_in_valid}, 32'd0);

        // Single frame from requester 0
        chk_busy = 1'b1;
        send(0, 1, 1'b0, -1, fw0);
        chk("first_grant_latency", fw0, 32'd1);
        drain();
        repeat (3) @(posedge clk);
        chk_busy = 1'b0;
        chk("single_grant_len", gcycles, 32'd256);
        chk("single_lasts", lcyc.size(), 32'd1);

        // Contention with a slow core: order 0,1,0,1, and the third grant
        // coincides with the first out_last while two frames are outstanding.
        lat = 600;
        reset_dut();
        fork
            send(0, 2, 1'b0, -1, fw0);
            send(1, 2, 1'b0, -1, fw1);
        join
        drain();
        chk("cont_ngrants", gid.size(), 32'd4);
        if (gid.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), gid[i], i % 2);
        end
        if (gcyc.size() >= 3 && lcyc.size() >= 1) chk("cont_slot_reuse", gcyc[2], lcyc[0] + 1);
        chk("cont_lasts", lcyc.size(), 32'd4);

        // Throttle: three back-to-back frames from requester 1
        reset_dut();
        send(1, 3, 1'b0, -1, fw1);
        drain();
        chk("thr_ngrants", gid.size(), 32'd3);
        if (gcyc.size() >= 3 && lcyc.size() >= 1) chk("thr_third_grant", gcyc[2], lcyc[0] + 1);
        if (gcyc.size() >= 2) chk("thr_second_grant", gcyc[1], gcyc[0] + 257);
        chk("thr_lasts", lcyc.size(), 32'd3);

        // Gapped input
        lat = 4;
        reset_dut();
        send(0, 1, 1'b1, -1, fw0);
        drain();
        chk("gap_grant_len", gcycles, 32'd512);
        chk("gap_pulses", pulses, 32'd256);

        // Stray core output with nothing in flight
        reset_dut();
        @(posedge clk);
        #1 inj = 1'b1;
        @(negedge clk);
        chk("stray_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stray_out_id", {31'd0, out_id}, 32'd0);
        @(posedge clk);
        #1 inj = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);

        // Reset mid-frame after 100 samples, then a clean frame
        lat = 600;
        send(0, 1, 1'b0, 100, fw0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_grant0", {31'd0, grant0}, 32'd0);
        chk("abort_grant1", {31'd0, grant1}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_busy_clr", {31'd0, busy}, 32'd0);
        exp_out.delete();
        exp_in.delete();
        lcyc.delete();
        gcycles = 0;
        lat = 4;
        send(0, 1, 1'b0, -1, fw0);
        drain();
        chk("restart_grant_len", gcycles, 32'd256);
        chk("restart_lasts", lcyc.size(), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
